// File: rtl/rollback_issue_buffer_if.sv
// Fetch-to-decode interface of the rollback issue buffer.
//   master : fetch/hazard side; drives flush, stall, rollback and the
//            3-wide fetch group (if_valid, if_inst, if_pc); observes
//            if_ready, the issue window (id_valid, id_inst, id_pc) and count.
//   slave  : the buffer itself.
// Way 0 is always the oldest instruction on both the fetch and issue sides.
interface rollback_issue_buffer_if #(
    parameter int DEPTH = 8
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic              flush;
    logic              stall;
    logic [1:0]        rollback;
    logic [2:0]        if_valid;
    logic [2:0][31:0]  if_inst;
    logic [2:0][31:0]  if_pc;
    logic              if_ready;
    logic [2:0]        id_valid;
    logic [2:0][31:0]  id_inst;
    logic [2:0][31:0]  id_pc;
    logic [CW-1:0]     count;

    modport master (
        output flush, stall, rollback, if_valid, if_inst, if_pc,
        input  if_ready, id_valid, id_inst, id_pc, count
    );

    modport slave (
        input  flush, stall, rollback, if_valid, if_inst, if_pc,
        output if_ready, id_valid, id_inst, id_pc, count
    );
endinterface

// File: rtl/rollback_issue_buffer.sv
// Rollback issue buffer: circular instruction FIFO between fetch and decode.
// Fetch pushes up to 3 instructions per cycle; decode sees the 3 oldest
// entries as an issue window.  When the hazard detector squashes the youngest
// issued ways (rollback), those entries are simply not popped, so they show
// up again from way 0 on the next cycle.
// Ports:
//   clock  : single clock, rising edge
//   reset  : synchronous, active-high
//   bus    : rollback_issue_buffer_if.slave (fetch group in, issue window out,
//            flush/stall/rollback controls, occupancy count)
// DEPTH must be a power of two (at least 8) so the pointers wrap for free.
module rollback_issue_buffer #(
    parameter int DEPTH = 8
) (
    input  logic                    clock,
    input  logic                    reset,
    rollback_issue_buffer_if.slave  bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [31:0]    r_mem_inst [DEPTH];
    logic [31:0]    r_mem_pc   [DEPTH];
    logic [AW-1:0]  r_head;
    logic [AW-1:0]  r_tail;
    logic [CW-1:0]  r_count;

    logic [AW-1:0]  w_rd_idx [3];
    logic [AW-1:0]  w_wr_off [3];
    logic [2:0]     w_id_valid;
    logic           w_if_ready;
    logic           w_push_en;
    logic [1:0]     w_push_n;
    logic [1:0]     w_issue_n;
    logic [1:0]     w_pop_n;

    always_comb begin
        for (int k = 0; k < 3; k++) begin
            w_rd_idx[k]   = r_head + AW'(k);
            w_id_valid[k] = (r_count > CW'(k));
        end

        // Readiness looks only at the registered count: a pop happening in
        // the same cycle earns no credit, which keeps if_ready off the
        // stall/rollback timing path.
        w_if_ready = (r_count <= CW'(DEPTH - 3));
        w_push_en  = w_if_ready && !bus.flush;

        // Write offsets count the valid ways below each way, so the pushed
        // entries land densely at the tail in way order.
        w_wr_off[0] = '0;
        w_wr_off[1] = AW'(bus.if_valid[0]);
        w_wr_off[2] = AW'(bus.if_valid[0]) + AW'(bus.if_valid[1]);

        w_push_n = 2'd0;
        if (w_push_en) begin
            w_push_n = 2'(bus.if_valid[0]) + 2'(bus.if_valid[1]) + 2'(bus.if_valid[2]);
        end

        w_issue_n = (r_count >= CW'(3)) ? 2'd3 : r_count[1:0];

        // Squashed ways stay at the head; only the older, surviving ways
        // retire.  A rollback covering every issued way retires nothing.
        w_pop_n = 2'd0;
        if (!bus.stall && (bus.rollback < w_issue_n)) begin
            w_pop_n = w_issue_n - bus.rollback;
        end
    end

    always_comb begin
        for (int k = 0; k < 3; k++) begin
            bus.id_inst[k] = r_mem_inst[w_rd_idx[k]];
            bus.id_pc[k]   = r_mem_pc[w_rd_idx[k]];
        end
    end

    assign bus.id_valid = w_id_valid;
    assign bus.if_ready = w_if_ready;
    assign bus.count    = r_count;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else if (bus.flush) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            r_head  <= r_head + AW'(w_pop_n);
            r_tail  <= r_tail + AW'(w_push_n);
            r_count <= r_count + CW'(w_push_n) - CW'(w_pop_n);
        end
    end

    // Entry storage carries no reset; entries beyond count are never shown
    // as valid, so stale contents are harmless.
    always_ff @(posedge clock) begin
        if (!reset && w_push_en) begin
            for (int k = 0; k < 3; k++) begin
                if (bus.if_valid[k]) begin
                    r_mem_inst[r_tail + w_wr_off[k]] <= bus.if_inst[k];
                    r_mem_pc[r_tail + w_wr_off[k]]   <= bus.if_pc[k];
                end
            end
        end
    end
endmodule

// File: doc/rollback_issue_buffer.md
ROLLBACK_ISSUE_BUFFER -- requirements
Module: rollback_issue_buffer

Interface
REQ-001 The block SHALL have parameter DEPTH, default 8: number of instruction entries; a power of two, at least 6.
REQ-002 The block SHALL have input `clock`, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have input `reset`, 1 bit: synchronous, active-high reset.
REQ-004 The block SHALL have input `flush`, 1 bit: discard all buffered instructions (branch redirect).
REQ-005 The block SHALL have input `stall`, 1 bit: the decode stage is frozen this cycle.
REQ-006 The block SHALL have input `rollback`, 2 bits: number of youngest issued ways squashed by the hazard detector (0-3).
REQ-007 The block SHALL have input `if_valid`, 3 bits: fetch-way valids; always contiguous from way 0 (000/001/011/111).
REQ-008 The block SHALL have input `if_inst`, 3x32 bits: fetched instructions, way 0 oldest.
REQ-009 The block SHALL have input `if_pc`, 3x32 bits: PCs of the fetched instructions.
REQ-010 The block SHALL have output `if_ready`, 1 bit: the buffer can accept a full 3-wide fetch group this cycle.
REQ-011 The block SHALL have output `id_valid`, 3 bits: issue-way valids, contiguous from way 0.
REQ-012 The block SHALL have outputs `id_inst` and `id_pc`, 3x32 bits each: issue window presented to decode, way 0 oldest.
REQ-013 The block SHALL have output `count`, log2(DEPTH)+1 bits: number of occupied entries.

Function
REQ-014 The block SHALL store entries in a circular FIFO with head pointer, tail pointer and count, all wrapping modulo DEPTH.
REQ-015 The block SHALL drive id way k combinationally from entry (head+k) mod DEPTH, with id_valid[k] = (count > k).
REQ-016 The block SHALL drive if_ready = (DEPTH - count >= 3), from the registered count only, with no credit for the same-cycle pop.
REQ-017 Push: when if_ready && !flush, the block SHALL write the popcount(if_valid) entries at the tail in way order, and advance the tail by that amount.
REQ-018 The block SHALL ignore fetch inputs when if_ready=0; fetch holds them.
REQ-019 Issue count: the block SHALL compute n = min(count, 3).
REQ-020 Pop: pop = 0 if stall; otherwise pop = n - rollback when rollback < n, else 0. Head advances by pop.
REQ-021 Rollback semantics: the squashed ways SHALL stay in the buffer and reappear starting at way 0 in the next cycle, in original order, followed by the next-oldest entries.
REQ-022 The block SHALL apply push and pop in the same cycle: count_next = count + push - pop, which never exceeds DEPTH.
REQ-023 Latency: a pushed instruction SHALL first appear on id_* the cycle after the push; there is no fetch-to-decode bypass.
REQ-024 Flush SHALL take highest priority: the next state is head=tail=0 and count=0; same-cycle push and pop are discarded.
REQ-025 The buffer SHALL never hold an instruction after it has been popped, and SHALL never pop an invalid way.

Reset
REQ-026 When reset=1 at a clock edge, the block SHALL set head=0, tail=0, count=0; the following cycle shows id_valid=000, if_ready=1, count=0.
REQ-027 Reset SHALL override flush, push and pop, including mid-rollback; no buffered entry survives reset.
REQ-028 Entry storage need not be cleared; id_inst and id_pc are don't-care while the matching id_valid bit is 0.

Verification
REQ-029 After reset, push PCs 0x00/0x04/0x08 (if_valid=111) -> next cycle id_valid=111, id_pc=00/04/08, count=3.
REQ-030 With count=6 (PCs 0x00-0x14) and rollback=2 -> next cycle id_pc=04/08/0C, count=5.
REQ-031 rollback=3 held for 2 cycles with no push -> window stays unchanged and count stays constant; then rollback=0 -> pop 3.
REQ-032 count=6 with DEPTH=8 -> if_ready=0, push ignored; after pop 3, if_ready=1 and a push of 3 brings count back to 6; tail wraps past entry 7 correctly.
REQ-033 count=2, rollback=3 -> pop 0; count=2, rollback=1 -> pop 1; stall=1 with rollback=0 -> pop 0.
REQ-034 flush with a simultaneous push of 3 and a pop -> next cycle count=0, id_valid=000; reset asserted during a rollback cycle -> count=0.
